clk_rst_seq: RTL



---
 rtl/clk_rst_seq_pkg.sv | 21 ++
 rtl/clk_rst_seq_sync_2ff.sv | 24 ++
 rtl/clk_rst_seq.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/clk_rst_seq_pkg.sv
// Shared types and constants for the clock-generator reset/lock sequencer.
package clk_rst_pkg;

    // Encodings are visible to software through state_o, so keep them fixed.
    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } state_t;

    localparam logic [7:0] LOCK_LOSS_MAX = 8'd255;

    // Saturating increment for the lock-loss statistic.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == LOCK_LOSS_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/clk_rst_seq_sync_2ff.sv
// Two-flop synchronizer for slow, level-type inputs crossing into clk.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; second stage gives it a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clk_rst_seq.sv
// Reset and lock sequencer for the board clock generator.
//
// state     | meaning
// ----------+------------------------------------------------------------
// RESET_PLL | generator held in reset for RST_CYCLES
// WAIT_LOCK | generator running, waiting for lock up to LOCK_TIMEOUT
// STABLE    | lock seen, must stay up for STABLE_CYCLES consecutive cycles
// RELEASE   | domain resets released one by one, STAGGER_CYCLES apart
// RUN       | everything released, watching for lock loss
// FAULT     | retries exhausted; parked until restart or rst_n
//
// A single down-counter serves every timed state; each transition reloads it
// for the state being entered. Domain k goes high on the clock edge that ends
// the k*STAGGER_CYCLES-th RELEASE cycle, so dom_rst_n[0] appears one cycle
// after RELEASE is entered (the output register).
module clk_rst_seq
    import clk_rst_pkg::*;
#(
    parameter int RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT   = 62500,
    parameter int STABLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES = 8,
    parameter int NUM_DOMAINS    = 5,
    parameter int MAX_RETRY      = 3,
    parameter int CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   restart,
    input  logic                   pll_locked_async,
    output logic                   pll_areset,
    output logic [NUM_DOMAINS-1:0] dom_rst_n,
    output logic                   all_ready,
    output logic                   fault,
    output logic [3:0]             retry_cnt,
    output logic [7:0]             lock_loss_cnt,
    output logic [2:0]             state_o
);

    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

    logic                   lk;
    logic                   lock_lost;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [3:0]             retry_q, retry_d;
    logic [7:0]             llc_q, llc_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   pll_areset_q, all_ready_q, fault_q;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked_async),
        .q     (lk)
    );

    // Next-state, counter, and status logic; restart outranks everything.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        llc_d     = llc_q;
        dom_d     = dom_q;
        lock_lost = !lk && (state_q == RELEASE || state_q == RUN);

        // Lock loss is counted even when a simultaneous restart takes the transition.
        if (lock_lost) begin
            llc_d = sat_inc8(llc_q);
        end

        if (restart) begin
            state_d = RESET_PLL;
            cnt_d   = RST_LOAD;
            idx_d   = '0;
            retry_d = '0;
            dom_d   = '0;
        end else if (lock_lost) begin
            state_d = RESET_PLL;
            cnt_d   = RST_LOAD;
            idx_d   = '0;
            dom_d   = '0;
        end else begin
            case (state_q)
                RESET_PLL: begin
                    dom_d = '0;
                    if (cnt_q == '0) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = TIMEOUT_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    dom_d = '0;
                    if (lk) begin
                        state_d = STABLE;
                        cnt_d   = STABLE_LOAD;
                    end else if (cnt_q == '0) begin
                        retry_d = retry_q + 4'd1;
                        if (retry_d == RETRY_LIMIT) begin
                            state_d = FAULT;
                        end else begin
                            state_d = RESET_PLL;
                            cnt_d   = RST_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                STABLE: begin
                    dom_d = '0;
                    if (!lk) begin
                        // A glitch restarts qualification but is not a failed attempt.
                        state_d = WAIT_LOCK;
                        cnt_d   = TIMEOUT_LOAD;
                    end else if (cnt_q == '0) begin
                        state_d = RELEASE;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cnt_q == '0) begin
                        for (int k = 0; k < NUM_DOMAINS; k++) begin
                            if (idx_q == IDX_W'(k)) begin
                                dom_d[k] = 1'b1;
                            end
                        end
                        if (idx_q == LAST_IDX) begin
                            state_d = RUN;
                            retry_d = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                            cnt_d = STAGGER_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                RUN: begin
                    retry_d = '0;
                end
                FAULT: begin
                    dom_d = '0;
                end
                default: begin
                    state_d = RESET_PLL;
                    cnt_d   = RST_LOAD;
                    idx_d   = '0;
                    dom_d   = '0;
                end
            endcase
        end
    end

    // State, counter and registered outputs; status flags decode the next state
    // so they line up with state_o on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RESET_PLL;
            cnt_q        <= RST_LOAD;
            idx_q        <= '0;
            retry_q      <= '0;
            llc_q        <= '0;
            dom_q        <= '0;
            pll_areset_q <= 1'b1;
            all_ready_q  <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            retry_q      <= retry_d;
            llc_q        <= llc_d;
            dom_q        <= dom_d;
            pll_areset_q <= (state_d == RESET_PLL) || (state_d == FAULT);
            all_ready_q  <= (state_d == RUN);
            fault_q      <= (state_d == FAULT);
        end
    end

    assign pll_areset    = pll_areset_q;
    assign dom_rst_n     = dom_q;
    assign all_ready     = all_ready_q;
    assign fault         = fault_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = llc_q;
    assign state_o       = state_q;

endmodule
